// File: rtl/y86_mem_pkg.sv
// ============================================================================
//  Module  : y86_mem_pkg
//  Purpose : Shared constants for the data-memory arbiter slice: FSM state
//            encoding, requester port ids, default memory size, and the
//            request legality check used when a request is latched.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package y86_mem_pkg;

  // Default data memory size in bytes.
  localparam int unsigned c_mem_bytes_default = 1024;

  // Arbiter FSM state encoding.
  localparam logic [1:0] c_st_idle   = 2'd0;
  localparam logic [1:0] c_st_access = 2'd1;
  localparam logic [1:0] c_st_resp   = 2'd2;

  // Requester port ids (p0 = CPU memory stage, p1 = loader/debug).
  localparam logic c_port_p0 = 1'b0;
  localparam logic c_port_p1 = 1'b1;

  // A request is illegal when it is neither a pure read nor a pure write, or
  // when the 8-byte word would run past the end of memory.
  function automatic logic dmem_req_illegal(
    input logic        rd,
    input logic        wr,
    input logic [63:0] addr,
    input logic [63:0] mem_bytes
  );
    return (rd == wr) || (addr > (mem_bytes - 64'd8));
  endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
// ============================================================================
//  Module  : dmem_arbiter_if
//  Purpose : Bundle of the two requester ports and the data-memory port of
//            the arbiter.
//            slave  : arbiter side (consumes requests, drives memory)
//            master : environment side (requesters + data memory)
//  Ports   : pN_valid/rd/wr/addr/wdata  requests, pN_done/rdata/err responses
//            mem_addr/wdata/rd_en/wr_en memory drive, mem_rdata/error returns
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

interface dmem_arbiter_if;

  logic        p0_valid;
  logic        p0_rd;
  logic        p0_wr;
  logic [63:0] p0_addr;
  logic [63:0] p0_wdata;
  logic        p0_done;
  logic [63:0] p0_rdata;
  logic        p0_err;

  logic        p1_valid;
  logic        p1_rd;
  logic        p1_wr;
  logic [63:0] p1_addr;
  logic [63:0] p1_wdata;
  logic        p1_done;
  logic [63:0] p1_rdata;
  logic        p1_err;

  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_rd_en;
  logic        mem_wr_en;
  logic [63:0] mem_rdata;
  logic        mem_error;

  modport slave (
    input  p0_valid, p0_rd, p0_wr, p0_addr, p0_wdata,
    output p0_done, p0_rdata, p0_err,
    input  p1_valid, p1_rd, p1_wr, p1_addr, p1_wdata,
    output p1_done, p1_rdata, p1_err,
    output mem_addr, mem_wdata, mem_rd_en, mem_wr_en,
    input  mem_rdata, mem_error
  );

  modport master (
    output p0_valid, p0_rd, p0_wr, p0_addr, p0_wdata,
    input  p0_done, p0_rdata, p0_err,
    output p1_valid, p1_rd, p1_wr, p1_addr, p1_wdata,
    input  p1_done, p1_rdata, p1_err,
    input  mem_addr, mem_wdata, mem_rd_en, mem_wr_en,
    output mem_rdata, mem_error
  );

endinterface

`default_nettype wire

// File: rtl/dmem_prio_sel.sv
// ============================================================================
//  Module  : dmem_prio_sel
//  Purpose : Grant selection between the two requesters with a starvation
//            guard. p0 normally wins; after STARVE_MAX consecutive p0 grants
//            while p1 is waiting, p1 is granted once.
//  Ports   : clk, reset      clock, synchronous active-high reset
//            p0_valid/p1_valid request pending flags
//            grant_en        a grant is being taken this cycle
//            grant_p1        1 = p1 selected, 0 = p0 selected
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module dmem_prio_sel #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic p0_valid,
  input  logic p1_valid,
  input  logic grant_en,
  output logic grant_p1
);

  localparam int unsigned c_cnt_w = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [c_cnt_w-1:0] c_starve_max = c_cnt_w'(STARVE_MAX);

  logic [c_cnt_w-1:0] r_starve;
  logic               w_starved;

  assign w_starved = (r_starve == c_starve_max);
  assign grant_p1  = p1_valid && (!p0_valid || w_starved);

  // Counts p0 grants taken while p1 is waiting; any gap in p1_valid or a
  // p1 grant restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_starve <= '0;
    end else if (!p1_valid) begin
      r_starve <= '0;
    end else if (grant_en) begin
      if (grant_p1) begin
        r_starve <= '0;
      end else if (!w_starved) begin
        r_starve <= r_starve + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
//  Module  : dmem_arbiter
//  Purpose : Two-port arbiter in front of the data memory. Each access runs
//            IDLE -> ACCESS -> RESP; the granted request is latched on entry
//            to ACCESS, the memory is strobed during ACCESS, and the response
//            (done/rdata/err) is registered on entry to RESP.
//  Ports   : clk, reset  clock, synchronous active-high reset
//            bus         dmem_arbiter_if.slave (requesters + memory)
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module dmem_arbiter
  import y86_mem_pkg::*;
#(
  parameter int unsigned MEM_BYTES  = c_mem_bytes_default,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic           clk,
  input  logic           reset,
  dmem_arbiter_if.slave  bus
);

  logic [1:0]  r_state;
  logic        r_port;
  logic        r_rd;
  logic        r_wr;
  logic        r_illegal;
  logic [63:0] r_addr;
  logic [63:0] r_wdata;

  logic        r_p0_done;
  logic        r_p0_err;
  logic [63:0] r_p0_rdata;
  logic        r_p1_done;
  logic        r_p1_err;
  logic [63:0] r_p1_rdata;

  logic        w_req_any;
  logic        w_grant_en;
  logic        w_grant_p1;
  logic        w_sel_rd;
  logic        w_sel_wr;
  logic [63:0] w_sel_addr;
  logic [63:0] w_sel_wdata;
  logic        w_access;
  logic        w_resp_err;
  logic [63:0] w_resp_rdata;

  assign w_req_any  = bus.p0_valid | bus.p1_valid;
  assign w_grant_en = (r_state == c_st_idle) && w_req_any;

  dmem_prio_sel #(
    .STARVE_MAX (STARVE_MAX)
  ) u_prio_sel (
    .clk      (clk),
    .reset    (reset),
    .p0_valid (bus.p0_valid),
    .p1_valid (bus.p1_valid),
    .grant_en (w_grant_en),
    .grant_p1 (w_grant_p1)
  );

  assign w_sel_rd    = w_grant_p1 ? bus.p1_rd    : bus.p0_rd;
  assign w_sel_wr    = w_grant_p1 ? bus.p1_wr    : bus.p0_wr;
  assign w_sel_addr  = w_grant_p1 ? bus.p1_addr  : bus.p0_addr;
  assign w_sel_wdata = w_grant_p1 ? bus.p1_wdata : bus.p0_wdata;

  // Read data is only meaningful for a legal read; mem_error is reported
  // even on an illegal request since it can only add to the error.
  assign w_resp_err   = r_illegal | bus.mem_error;
  assign w_resp_rdata = (!r_illegal && r_rd) ? bus.mem_rdata : 64'h0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= c_st_idle;
      r_port     <= c_port_p0;
      r_rd       <= 1'b0;
      r_wr       <= 1'b0;
      r_illegal  <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_p0_done  <= 1'b0;
      r_p0_err   <= 1'b0;
      r_p0_rdata <= '0;
      r_p1_done  <= 1'b0;
      r_p1_err   <= 1'b0;
      r_p1_rdata <= '0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (w_req_any) begin
            r_state   <= c_st_access;
            r_port    <= w_grant_p1 ? c_port_p1 : c_port_p0;
            r_rd      <= w_sel_rd;
            r_wr      <= w_sel_wr;
            r_addr    <= w_sel_addr;
            r_wdata   <= w_sel_wdata;
            r_illegal <= dmem_req_illegal(w_sel_rd, w_sel_wr, w_sel_addr,
                                          64'(MEM_BYTES));
          end
        end
        c_st_access: begin
          r_state <= c_st_resp;
          // Only the granted port's response registers move; the other
          // port keeps its last result.
          if (r_port == c_port_p1) begin
            r_p1_done  <= 1'b1;
            r_p1_err   <= w_resp_err;
            r_p1_rdata <= w_resp_rdata;
          end else begin
            r_p0_done  <= 1'b1;
            r_p0_err   <= w_resp_err;
            r_p0_rdata <= w_resp_rdata;
          end
        end
        c_st_resp: begin
          r_state   <= c_st_idle;
          r_p0_done <= 1'b0;
          r_p1_done <= 1'b0;
        end
        default: begin
          r_state   <= c_st_idle;
          r_p0_done <= 1'b0;
          r_p1_done <= 1'b0;
        end
      endcase
    end
  end

  assign w_access = (r_state == c_st_access) && !r_illegal;

  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.mem_rd_en = w_access && r_rd;
  assign bus.mem_wr_en = w_access && r_wr;

  assign bus.p0_done  = r_p0_done;
  assign bus.p0_err   = r_p0_err;
  assign bus.p0_rdata = r_p0_rdata;
  assign bus.p1_done  = r_p1_done;
  assign bus.p1_err   = r_p1_err;
  assign bus.p1_rdata = r_p1_rdata;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
//  Module  : tb_dmem_arbiter
//  Purpose : Self-checking bench for dmem_arbiter: byte-array data memory
//            model, directed scenarios and randomized transactions compared
//            against a byte-level reference memory and per-port result model.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dmem_arbiter;

  localparam int unsigned MEM_BYTES  = 1024;
  localparam int unsigned STARVE_MAX = 4;
  localparam int unsigned c_aw       = $clog2(MEM_BYTES);

  logic clk = 1'b0;
  logic reset;
  logic force_err;

  always #5 clk = ~clk;

  dmem_arbiter_if bus ();

  dmem_arbiter #(
    .MEM_BYTES  (MEM_BYTES),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Data memory: combinational little-endian read, write on falling edge.
  logic [7:0] mem [MEM_BYTES];

  always_comb begin
    bus.mem_rdata = '0;
    for (int i = 0; i < 8; i++) begin
      if (bus.mem_addr + 64'(i) < 64'(MEM_BYTES))
        bus.mem_rdata[8*i +: 8] = mem[c_aw'(bus.mem_addr + 64'(i))];
    end
  end

  assign bus.mem_error = force_err;

  always @(negedge clk) begin
    if (bus.mem_wr_en) begin
      for (int i = 0; i < 8; i++) begin
        if (bus.mem_addr + 64'(i) < 64'(MEM_BYTES))
          mem[c_aw'(bus.mem_addr + 64'(i))] <= bus.mem_wdata[8*i +: 8];
      end
    end
  end

  // Reference model state.
  logic [7:0]  ref_mem [MEM_BYTES];
  logic [63:0] exp_rdata [2];
  logic        exp_err   [2];

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_read(input logic [63:0] a);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 8; i++)
      if (a + 64'(i) < 64'(MEM_BYTES)) r[8*i +: 8] = ref_mem[c_aw'(a + 64'(i))];
    return r;
  endfunction

  task automatic ref_write(input logic [63:0] a, input logic [63:0] d);
    for (int i = 0; i < 8; i++)
      if (a + 64'(i) < 64'(MEM_BYTES)) ref_mem[c_aw'(a + 64'(i))] = d[8*i +: 8];
  endtask

  task automatic drive_port(input int port, input logic v, input logic rd, input logic wr,
                            input logic [63:0] addr, input logic [63:0] wdata);
    if (port == 0) begin
      bus.p0_valid = v; bus.p0_rd = rd; bus.p0_wr = wr;
      bus.p0_addr = addr; bus.p0_wdata = wdata;
    end else begin
      bus.p1_valid = v; bus.p1_rd = rd; bus.p1_wr = wr;
      bus.p1_addr = addr; bus.p1_wdata = wdata;
    end
  endtask

  // One complete transaction on a single port, checked end to end.
  task automatic run_txn(input string pfx, input int port, input logic rd, input logic wr,
                         input logic [63:0] addr, input logic [63:0] wdata, input logic merr);
    logic legal;
    int   edges;
    bit   got, saw_rd, saw_wr, saw_other;
    int   other;
    other = 1 - port;
    legal = (rd != wr) && (addr <= 64'(MEM_BYTES - 8));
    drive_port(port, 1'b1, rd, wr, addr, wdata);
    force_err = merr;
    got = 0; saw_rd = 0; saw_wr = 0; saw_other = 0; edges = 0;
    while (!got && edges < 8) begin
      @(posedge clk); #1;
      edges++;
      if (bus.mem_rd_en) saw_rd = 1;
      if (bus.mem_wr_en) saw_wr = 1;
      if ((port == 0) ? bus.p1_done : bus.p0_done) saw_other = 1;
      if ((port == 0) ? bus.p0_done : bus.p1_done) got = 1;
    end
    exp_rdata[port] = (legal && rd) ? ref_read(addr) : 64'h0;
    exp_err[port]   = !legal || merr;
    chk({pfx, "_done"}, 64'(got), 64'd1);
    chk({pfx, "_latency"}, 64'(edges), 64'd2);
    chk({pfx, "_rdata"}, (port == 0) ? bus.p0_rdata : bus.p1_rdata, exp_rdata[port]);
    chk({pfx, "_err"}, 64'((port == 0) ? bus.p0_err : bus.p1_err), 64'(exp_err[port]));
    chk({pfx, "_rd_en_seen"}, 64'(saw_rd), 64'(legal && rd));
    chk({pfx, "_wr_en_seen"}, 64'(saw_wr), 64'(legal && wr));
    chk({pfx, "_other_done"}, 64'(saw_other), 64'd0);
    chk({pfx, "_other_rdata_hold"}, (other == 0) ? bus.p0_rdata : bus.p1_rdata, exp_rdata[other]);
    if (legal && wr) ref_write(addr, wdata);
    drive_port(port, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
    force_err = 1'b0;
    @(posedge clk); #1;
    chk({pfx, "_done_one_cycle"}, 64'((port == 0) ? bus.p0_done : bus.p1_done), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   p1_run;
    bit   got, which, exp_p1;
    int   edges;
    int   port, kind;
    logic rd, wr, merr;
    logic [63:0] addr, wdata;

    for (int i = 0; i < int'(MEM_BYTES); i++) begin
      mem[i]     = 8'(i * 37 + 5);
      ref_mem[i] = 8'(i * 37 + 5);
    end
    mem[208] = 8'd60; ref_mem[208] = 8'd60;
    exp_rdata[0] = '0; exp_rdata[1] = '0; exp_err[0] = 1'b0; exp_err[1] = 1'b0;
    force_err = 1'b0;
    drive_port(0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
    drive_port(1, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0);

    // Reset state.
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_p0_done", 64'(bus.p0_done), 64'd0);
    chk("rst_p1_done", 64'(bus.p1_done), 64'd0);
    chk("rst_p0_rdata", bus.p0_rdata, 64'h0);
    chk("rst_mem_rd_en", 64'(bus.mem_rd_en), 64'd0);
    chk("rst_mem_wr_en", 64'(bus.mem_wr_en), 64'd0);
    chk("rst_mem_addr", bus.mem_addr, 64'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed write then read-back on p0.
    run_txn("p0_wr200", 0, 1'b0, 1'b1, 64'd200, 64'h1122334455667788, 1'b0);
    run_txn("p0_rd200", 0, 1'b1, 1'b0, 64'd200, 64'h0, 1'b0);
    chk("p0_rd200_value", bus.p0_rdata, 64'h1122334455667788);

    // Boundary addresses on p1.
    run_txn("p1_rd1016", 1, 1'b1, 1'b0, 64'd1016, 64'h0, 1'b0);
    run_txn("p1_rd1017", 1, 1'b1, 1'b0, 64'd1017, 64'h0, 1'b0);

    // Bad command encodings on p0.
    run_txn("p0_rdwr208", 0, 1'b1, 1'b1, 64'd208, 64'hDEADBEEFDEADBEEF, 1'b0);
    chk("mem208_unchanged", 64'(mem[208]), 64'd60);
    run_txn("p0_none", 0, 1'b0, 1'b0, 64'd8, 64'h0, 1'b0);

    // Memory error on a legal p1 read.
    run_txn("p1_memerr", 1, 1'b1, 1'b0, 64'd64, 64'h0, 1'b1);

    // Both ports held valid: p1 gets one grant after every STARVE_MAX p0 grants.
    drive_port(0, 1'b1, 1'b1, 1'b0, 64'd0, 64'h0);
    drive_port(1, 1'b1, 1'b1, 1'b0, 64'd8, 64'h0);
    p1_run = 0;
    for (int g = 0; g < 10; g++) begin
      exp_p1 = (p1_run == int'(STARVE_MAX));
      got = 0; which = 0; edges = 0;
      while (!got && edges < 6) begin
        @(posedge clk); #1;
        edges++;
        if (bus.p0_done || bus.p1_done) begin
          got = 1;
          which = bus.p1_done;
        end
      end
      chk($sformatf("starve_grant%0d_seen", g), 64'(got), 64'd1);
      chk($sformatf("starve_grant%0d_port", g), 64'(which), 64'(exp_p1));
      p1_run = exp_p1 ? 0 : p1_run + 1;
    end
    drive_port(0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
    drive_port(1, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
    exp_rdata[0] = ref_read(64'd0); exp_err[0] = 1'b0;
    exp_rdata[1] = ref_read(64'd8); exp_err[1] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("starve_p0_rdata", bus.p0_rdata, exp_rdata[0]);
    chk("starve_p1_rdata", bus.p1_rdata, exp_rdata[1]);

    // Reset during ACCESS of a p0 write aborts the transaction.
    drive_port(0, 1'b1, 1'b0, 1'b1, 64'd16, 64'hA5A5A5A5_5A5A5A5A);
    @(posedge clk); #1;
    chk("abort_wr_en_in_access", 64'(bus.mem_wr_en), 64'd1);
    reset = 1'b1;
    drive_port(0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
    @(posedge clk); #1;
    chk("abort_p0_done", 64'(bus.p0_done), 64'd0);
    chk("abort_mem_wr_en", 64'(bus.mem_wr_en), 64'd0);
    chk("abort_mem_rd_en", 64'(bus.mem_rd_en), 64'd0);
    chk("abort_mem_addr", bus.mem_addr, 64'h0);
    chk("abort_mem_wdata", bus.mem_wdata, 64'h0);
    chk("abort_p0_rdata", bus.p0_rdata, 64'h0);
    chk("abort_p1_rdata", bus.p1_rdata, 64'h0);
    chk("abort_p1_err", 64'(bus.p1_err), 64'd0);
    reset = 1'b0;
    // The write strobe was already high across the ACCESS falling edge.
    ref_write(64'd16, 64'hA5A5A5A5_5A5A5A5A);
    exp_rdata[0] = '0; exp_rdata[1] = '0; exp_err[0] = 1'b0; exp_err[1] = 1'b0;
    @(posedge clk); #1;
    chk("abort_no_late_done", 64'(bus.p0_done), 64'd0);
    run_txn("post_abort_rd16", 0, 1'b1, 1'b0, 64'd16, 64'h0, 1'b0);

    // Randomized transactions.
    for (int t = 0; t < 40; t++) begin
      port = int'($urandom_range(0, 1));
      kind = int'($urandom_range(0, 9));
      rd = (kind == 0) || (kind >= 2 && kind <= 5);
      wr = (kind == 0) || (kind >= 6);
      if ($urandom_range(0, 7) == 0)
        addr = 64'($urandom_range(MEM_BYTES - 12, MEM_BYTES + 4));
      else
        addr = 64'($urandom_range(0, MEM_BYTES - 8));
      wdata = {$urandom, $urandom};
      merr  = ($urandom_range(0, 7) == 0);
      run_txn($sformatf("rnd%0d", t), port, rd, wr, addr, wdata, merr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
